// File: rtl/data_memory.sv
// data_memory: 16 x 8 data memory for the i281 CPU.
//
// Holds the program's data bytes. The initial image (b0I..b15I) is copied in
// all at once on reset, or one byte per cycle on a Reload request. The
// datapath reads combinationally and writes with one cycle of latency. A
// valid/ready dump port streams addresses 0..15 in order to a consumer.
//
// A single 4-bit pointer is shared by the LOAD and DUMP walks. It returns to
// zero explicitly at the end of each walk and never relies on wrap-around.
module data_memory (
    input  logic       Clock,
    input  logic       Reset_n,

    // Initial image from the user-data block
    input  logic [7:0] b0I,
    input  logic [7:0] b1I,
    input  logic [7:0] b2I,
    input  logic [7:0] b3I,
    input  logic [7:0] b4I,
    input  logic [7:0] b5I,
    input  logic [7:0] b6I,
    input  logic [7:0] b7I,
    input  logic [7:0] b8I,
    input  logic [7:0] b9I,
    input  logic [7:0] b10I,
    input  logic [7:0] b11I,
    input  logic [7:0] b12I,
    input  logic [7:0] b13I,
    input  logic [7:0] b14I,
    input  logic [7:0] b15I,
    input  logic       Reload,

    // Datapath port
    input  logic       Write_Enable,
    input  logic [3:0] Write_Address,
    input  logic [7:0] Write_Data,
    input  logic [3:0] Read_Address,
    output logic [7:0] Read_Data,
    output logic       Busy,
    output logic       Write_Dropped,

    // Dump port
    input  logic       Dump_Start,
    output logic       Dump_Valid,
    input  logic       Dump_Ready,
    output logic [3:0] Dump_Address,
    output logic [7:0] Dump_Data,
    output logic       Dump_Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'd15;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_ptr;
    logic [3:0] w_ptr_next;

    logic [7:0] r_mem  [16];
    logic [7:0] w_init [16];

    logic       r_dump_done;
    logic       r_write_dropped;

    logic       w_busy;
    logic       w_dump_accept;
    logic       w_dump_last;
    logic       w_idle_write;
    logic       w_load_active;

    // Gather the initial image into an indexable array.
    assign w_init[0]  = b0I;
    assign w_init[1]  = b1I;
    assign w_init[2]  = b2I;
    assign w_init[3]  = b3I;
    assign w_init[4]  = b4I;
    assign w_init[5]  = b5I;
    assign w_init[6]  = b6I;
    assign w_init[7]  = b7I;
    assign w_init[8]  = b8I;
    assign w_init[9]  = b9I;
    assign w_init[10] = b10I;
    assign w_init[11] = b11I;
    assign w_init[12] = b12I;
    assign w_init[13] = b13I;
    assign w_init[14] = b14I;
    assign w_init[15] = b15I;

    // Decoded control conditions.
    assign w_busy        = (r_state != ST_IDLE);
    assign w_load_active = (r_state == ST_LOAD);
    assign w_dump_accept = (r_state == ST_DUMP) && Dump_Ready;
    assign w_dump_last   = w_dump_accept && (r_ptr == LAST_ADDR);
    // Datapath writes land only while idle; during LOAD/DUMP they are dropped.
    assign w_idle_write  = (r_state == ST_IDLE) && Write_Enable;

    // Next-state and next-pointer decode.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                // Reload has priority; a simultaneous Dump_Start is dropped.
                if (Reload) begin
                    w_state_next = ST_LOAD;
                    w_ptr_next   = 4'd0;
                end else if (Dump_Start) begin
                    w_state_next = ST_DUMP;
                    w_ptr_next   = 4'd0;
                end
            end
            ST_LOAD: begin
                if (r_ptr == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = 4'd0;
                end else begin
                    w_ptr_next = r_ptr + 4'd1;
                end
            end
            ST_DUMP: begin
                if (w_dump_last) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = 4'd0;
                end else if (w_dump_accept) begin
                    w_ptr_next = r_ptr + 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ptr_next   = 4'd0;
            end
        endcase
    end

    // State and pointer registers; reset aborts any walk in progress.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Storage array: bulk copy on reset, byte-per-cycle copy during LOAD,
    // datapath writes while idle.
    always_ff @(posedge Clock) begin
        // NOTE: this memory is deliberately reset. Reset is how the program's
        // initial data image gets in, so it is function, not initialisation,
        // and the array is built from flops rather than a RAM macro.
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= w_init[i];
            end
        end else if (w_load_active) begin
            r_mem[r_ptr] <= w_init[r_ptr];
        end else if (w_idle_write) begin
            r_mem[Write_Address] <= Write_Data;
        end
    end

    // One-cycle status pulses: dump completion and dropped writes.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_dump_done     <= 1'b0;
            r_write_dropped <= 1'b0;
        end else begin
            r_dump_done     <= w_dump_last;
            r_write_dropped <= w_busy && Write_Enable;
        end
    end

    // Outputs. Reads are combinational, so a write to the address being
    // read shows the old byte until the following cycle.
    assign Read_Data     = r_mem[Read_Address];
    assign Busy          = w_busy;
    assign Write_Dropped = r_write_dropped;
    assign Dump_Valid    = (r_state == ST_DUMP);
    assign Dump_Address  = r_ptr;
    assign Dump_Data     = r_mem[r_ptr];
    assign Dump_Done     = r_dump_done;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: self-checking bench for data_memory.
// Keeps its own memory image, and a scoreboard queue of the bytes a dump
// is expected to deliver.
module tb_data_memory;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } dump_item_t;

    logic       Clock;
    logic       Reset_n;
    logic [7:0] b_val [16];
    logic       Reload;
    logic       Write_Enable;
    logic [3:0] Write_Address;
    logic [7:0] Write_Data;
    logic [3:0] Read_Address;
    logic [7:0] Read_Data;
    logic       Busy;
    logic       Write_Dropped;
    logic       Dump_Start;
    logic       Dump_Valid;
    logic       Dump_Ready;
    logic [3:0] Dump_Address;
    logic [7:0] Dump_Data;
    logic       Dump_Done;

    logic [7:0] exp_mem [16];
    dump_item_t sb_q [$];

    int n_checks;
    int n_errors;

    data_memory dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .b0I          (b_val[0]),
        .b1I          (b_val[1]),
        .b2I          (b_val[2]),
        .b3I          (b_val[3]),
        .b4I          (b_val[4]),
        .b5I          (b_val[5]),
        .b6I          (b_val[6]),
        .b7I          (b_val[7]),
        .b8I          (b_val[8]),
        .b9I          (b_val[9]),
        .b10I         (b_val[10]),
        .b11I         (b_val[11]),
        .b12I         (b_val[12]),
        .b13I         (b_val[13]),
        .b14I         (b_val[14]),
        .b15I         (b_val[15]),
        .Reload       (Reload),
        .Write_Enable (Write_Enable),
        .Write_Address(Write_Address),
        .Write_Data   (Write_Data),
        .Read_Address (Read_Address),
        .Read_Data    (Read_Data),
        .Busy         (Busy),
        .Write_Dropped(Write_Dropped),
        .Dump_Start   (Dump_Start),
        .Dump_Valid   (Dump_Valid),
        .Dump_Ready   (Dump_Ready),
        .Dump_Address (Dump_Address),
        .Dump_Data    (Dump_Data),
        .Dump_Done    (Dump_Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) b_val[i] = 8'h00;
        b_val[0] = 8'hBB;
        b_val[1] = 8'h77;
        Reset_n = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
        exp_mem = b_val;
        Read_Address = 4'd0; #1;
        n_checks++;
        if (Read_Data !== 8'hBB) begin
            n_errors++; $display("FAIL reset_addr0: got %h expected bb", Read_Data);
        end
        Read_Address = 4'd1; #1;
        n_checks++;
        if (Read_Data !== 8'h77) begin
            n_errors++; $display("FAIL reset_addr1: got %h expected 77", Read_Data);
        end
        Read_Address = 4'd8; #1;
        n_checks++;
        if (Read_Data !== 8'h00) begin
            n_errors++; $display("FAIL reset_addr8: got %h expected 00", Read_Data);
        end
        n_checks++;
        if ({Busy, Dump_Valid, Dump_Done, Write_Dropped} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got busy/valid/done/dropped=%b expected 0000",
                     {Busy, Dump_Valid, Dump_Done, Write_Dropped});
        end
    endtask

    task automatic test_write_read();
        step();
        Read_Address  = 4'd9;
        Write_Enable  = 1'b1;
        Write_Address = 4'd9;
        Write_Data    = 8'h5A;
        #1;
        n_checks++;
        if (Read_Data !== exp_mem[9]) begin
            n_errors++; $display("FAIL write_cycle_old: got %h expected %h", Read_Data, exp_mem[9]);
        end
        step();
        Write_Enable = 1'b0;
        exp_mem[9] = 8'h5A;
        n_checks++;
        if (Read_Data !== 8'h5A) begin
            n_errors++; $display("FAIL write_next_new: got %h expected 5a", Read_Data);
        end
    endtask

    // Reload sampled at edge N: address 9 changes at edge N+10, Busy lasts 16 cycles.
    task automatic test_reload_timing();
        int busy_cnt;
        Reload = 1'b1;
        step();
        Reload = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (Busy) busy_cnt++;
            if (k == 0) begin
                n_checks++;
                if (Busy !== 1'b1) begin
                    n_errors++; $display("FAIL reload_busy_first: got %b expected 1", Busy);
                end
            end
            if (k == 16) begin
                n_checks++;
                if (Busy !== 1'b0) begin
                    n_errors++; $display("FAIL reload_busy_end: got %b expected 0", Busy);
                end
            end
            if (k == 9) begin
                n_checks++;
                if (Read_Data !== exp_mem[9]) begin
                    n_errors++; $display("FAIL reload_addr9_before: got %h expected %h", Read_Data, exp_mem[9]);
                end
            end
            if (k == 10) begin
                n_checks++;
                if (Read_Data !== b_val[9]) begin
                    n_errors++; $display("FAIL reload_addr9_after: got %h expected %h", Read_Data, b_val[9]);
                end
            end
            step();
        end
        exp_mem = b_val;
        n_checks++;
        if (busy_cnt != 16) begin
            n_errors++; $display("FAIL reload_busy_cycles: got %0d expected 16", busy_cnt);
        end
    endtask

    task automatic test_load_write_drop();
        bit idle_seen;
        for (int i = 0; i < 16; i++) b_val[i] = 8'(i * 17 + 3);
        Reload = 1'b1;
        step();
        Reload = 1'b0;
        Write_Enable  = 1'b1;
        Write_Address = 4'd3;
        Write_Data    = 8'hFF;
        step();
        Write_Enable = 1'b0;
        n_checks++;
        if (Write_Dropped !== 1'b1) begin
            n_errors++; $display("FAIL drop_pulse_a3: got %b expected 1", Write_Dropped);
        end
        step();
        n_checks++;
        if (Write_Dropped !== 1'b0) begin
            n_errors++; $display("FAIL drop_pulse_width: got %b expected 0", Write_Dropped);
        end
        // Address 0 is already reloaded here, so an accepted write would stick.
        Write_Enable  = 1'b1;
        Write_Address = 4'd0;
        step();
        Write_Enable = 1'b0;
        n_checks++;
        if (Write_Dropped !== 1'b1) begin
            n_errors++; $display("FAIL drop_pulse_a0: got %b expected 1", Write_Dropped);
        end
        idle_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (!Busy) begin
                idle_seen = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (!idle_seen) begin
            n_errors++; $display("FAIL load_timeout: got busy expected idle within 30 cycles");
        end
        exp_mem = b_val;
        for (int i = 0; i < 16; i++) begin
            Read_Address = 4'(i); #1;
            n_checks++;
            if (Read_Data !== exp_mem[i]) begin
                n_errors++; $display("FAIL load_image[%0d]: got %h expected %h", i, Read_Data, exp_mem[i]);
            end
        end
    endtask

    task automatic test_reload_vs_dump();
        int busy_cnt;
        int valid_cnt;
        step();
        for (int i = 0; i < 16; i++) b_val[i] = 8'(8'hF0 - i * 5);
        Reload     = 1'b1;
        Dump_Start = 1'b1;
        step();
        Reload     = 1'b0;
        Dump_Start = 1'b0;
        busy_cnt  = 0;
        valid_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (Busy) busy_cnt++;
            if (Dump_Valid) valid_cnt++;
            step();
        end
        exp_mem = b_val;
        n_checks++;
        if (valid_cnt != 0) begin
            n_errors++; $display("FAIL collide_no_dump: got %0d valid cycles expected 0", valid_cnt);
        end
        n_checks++;
        if (busy_cnt != 16) begin
            n_errors++; $display("FAIL collide_load_len: got %0d expected 16", busy_cnt);
        end
        Read_Address = 4'd7; #1;
        n_checks++;
        if (Read_Data !== exp_mem[7]) begin
            n_errors++; $display("FAIL collide_loaded: got %h expected %h", Read_Data, exp_mem[7]);
        end
    endtask

    // Ready pattern 1,0,0 repeating; scoreboard holds the 16 expected bytes.
    task automatic test_dump_backpressure();
        dump_item_t exp_item;
        logic [3:0] last_addr;
        logic [7:0] last_data;
        bit         prev_stall;
        int         done_cnt;
        int         tail;
        step();
        for (int i = 0; i < 16; i++) sb_q.push_back({4'(i), exp_mem[i]});
        Dump_Start = 1'b1;
        step();
        Dump_Start = 1'b0;
        done_cnt   = 0;
        tail       = 0;
        prev_stall = 1'b0;
        last_addr  = 4'd0;
        last_data  = 8'd0;
        for (int cyc = 0; cyc < 200 && tail < 3; cyc++) begin
            Dump_Ready = (cyc % 3 == 0);
            #1;
            if (Dump_Done) done_cnt++;
            if (sb_q.size() > 0) begin
                exp_item = sb_q[0];
                n_checks++;
                if (Dump_Valid !== 1'b1 || Dump_Address !== exp_item.addr || Dump_Data !== exp_item.data) begin
                    n_errors++;
                    $display("FAIL dump_byte: got v=%b a=%0d d=%h expected v=1 a=%0d d=%h",
                             Dump_Valid, Dump_Address, Dump_Data, exp_item.addr, exp_item.data);
                end
                if (prev_stall) begin
                    n_checks++;
                    if (Dump_Address !== last_addr || Dump_Data !== last_data) begin
                        n_errors++;
                        $display("FAIL dump_stall_stable: got a=%0d d=%h expected a=%0d d=%h",
                                 Dump_Address, Dump_Data, last_addr, last_data);
                    end
                end
                last_addr  = Dump_Address;
                last_data  = Dump_Data;
                prev_stall = !Dump_Ready;
                if (Dump_Ready && Dump_Valid) void'(sb_q.pop_front());
            end else begin
                if (tail == 0) begin
                    n_checks++;
                    if (Dump_Done !== 1'b1 || Dump_Valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL dump_done_timing: got done=%b valid=%b expected done=1 valid=0",
                                 Dump_Done, Dump_Valid);
                    end
                end
                tail++;
            end
            step();
        end
        Dump_Ready = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++; $display("FAIL dump_timeout: got %0d bytes left expected 0", sb_q.size());
            sb_q.delete();
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_errors++; $display("FAIL dump_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    // Full-speed dump, restart in the Dump_Done cycle, then reset mid-dump.
    task automatic test_restart_and_reset();
        int valid_cnt;
        bit got_done;
        bit reached;
        step();
        Dump_Ready = 1'b1;
        Dump_Start = 1'b1;
        step();
        Dump_Start = 1'b0;
        valid_cnt = 0;
        got_done  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (Dump_Done) begin
                got_done = 1'b1;
                break;
            end
            if (Dump_Valid) valid_cnt++;
            step();
        end
        n_checks++;
        if (!got_done || valid_cnt != 16) begin
            n_errors++; $display("FAIL full_speed_dump: got done=%b valid_cycles=%0d expected done=1 valid_cycles=16",
                                 got_done, valid_cnt);
        end
        // In the Dump_Done cycle: restart the dump and write address 5.
        Dump_Start    = 1'b1;
        Write_Enable  = 1'b1;
        Write_Address = 4'd5;
        Write_Data    = 8'hEE;
        step();
        Dump_Start   = 1'b0;
        Write_Enable = 1'b0;
        exp_mem[5]   = 8'hEE;
        n_checks++;
        if (Dump_Valid !== 1'b1 || Dump_Address !== 4'd0) begin
            n_errors++; $display("FAIL restart_in_done: got v=%b a=%0d expected v=1 a=0", Dump_Valid, Dump_Address);
        end
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (Dump_Address == 4'd5) begin
                n_checks++;
                if (Dump_Data !== exp_mem[5]) begin
                    n_errors++; $display("FAIL restart_write_seen: got %h expected %h", Dump_Data, exp_mem[5]);
                end
            end
            if (Dump_Address == 4'd6) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (!reached) begin
            n_errors++; $display("FAIL reach_addr6: got address %0d expected 6", Dump_Address);
        end
        for (int i = 0; i < 16; i++) b_val[i] = 8'(8'hA0 ^ i);
        Reset_n = 1'b0;
        step();
        Reset_n    = 1'b1;
        Dump_Ready = 1'b0;
        exp_mem    = b_val;
        n_checks++;
        if (Dump_Valid !== 1'b0 || Busy !== 1'b0 || Dump_Done !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_dump: got v=%b busy=%b done=%b expected 0 0 0",
                                 Dump_Valid, Busy, Dump_Done);
        end
        for (int i = 0; i < 16; i++) begin
            Read_Address = 4'(i); #1;
            n_checks++;
            if (Read_Data !== exp_mem[i]) begin
                n_errors++; $display("FAIL reset_image[%0d]: got %h expected %h", i, Read_Data, exp_mem[i]);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        Reset_n       = 1'b0;
        Reload        = 1'b0;
        Write_Enable  = 1'b0;
        Write_Address = 4'd0;
        Write_Data    = 8'd0;
        Read_Address  = 4'd0;
        Dump_Start    = 1'b0;
        Dump_Ready    = 1'b0;
        for (int i = 0; i < 16; i++) b_val[i] = 8'h00;

        test_reset();
        test_write_read();
        test_reload_timing();
        test_load_write_drop();
        test_reload_vs_dump();
        test_dump_backpressure();
        test_restart_and_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
